// File: rtl/sfrx_pkg.sv
// Shared types and constants for the serial frame receiver.
package sfrx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_WAIT_HIGH = 2'd2
  } sfrx_state_e;

  localparam int FRAME_BITS_DEFAULT = 24;

  localparam logic [7:0] CTRL_LOAD_A = 8'h10;
  localparam logic [7:0] CTRL_LOAD_B = 8'h24;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sfrx_sync_edge.sv
// Synchronizer for one asynchronous input, optional 3-sample majority filter,
// registered level plus one-cycle rise/fall pulses aligned with that level.
module sfrx_sync_edge
  import sfrx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit USE_FILTER  = 1'b0
) (
  input  logic clk_100M,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   filt;

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
    end
  end

  generate
    if (USE_FILTER) begin : g_filter
      logic [1:0] hist;
      logic       filt_q;

      // Needs 2 of the last 3 samples to agree; a single-sample blip never propagates.
      always_ff @(posedge clk_100M) begin
        if (rst) begin
          hist   <= '1;
          filt_q <= 1'b1;
        end else begin
          hist   <= {hist[0], sync_ff[SYNC_STAGES-1]};
          filt_q <= majority3(sync_ff[SYNC_STAGES-1], hist[0], hist[1]);
        end
      end

      assign filt = filt_q;
    end else begin : g_no_filter
      assign filt = sync_ff[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= filt;
      rise  <= filt & ~level;
      fall  <= ~filt & level;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Receives FRAME_BITS-bit MSB-first frames framed by an active-low sync strobe.
// Define SFRX_GLITCH_FILTER_EN to add a 3-sample majority filter on sclk and sync.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_WAIT_HIGH | after reset: wait until sync has been settled high
// ST_IDLE      | waiting for sync falling edge to start a frame
// ST_SHIFT     | shifting on sclk falling edges until sync rises
module serial_frame_rx
  import sfrx_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_100M,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  sdata,
  input  logic                  sync,
  output logic [FRAME_BITS-1:0] word,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic [15:0]           frame_cnt
);

`ifdef SFRX_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  localparam int              CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  // Longer than the sync pipeline, so a low sync pin seen at reset is observed before leaving WAIT_HIGH.
  localparam int         SETTLE      = SYNC_STAGES + 3 + (FILT_EN ? 2 : 0);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdata_lvl, sdata_rise, sdata_fall;
  logic sync_lvl, sync_rise, sync_fall;
  logic unused_edges;

  sfrx_state_e state, state_nxt;

  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [7:0]            settle_cnt;

  logic cnt_clr, shift_en, frame_good, frame_bad;

  sfrx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .USE_FILTER(FILT_EN)) u_sclk (
    .clk_100M (clk_100M),
    .rst      (rst),
    .din      (sclk),
    .level    (sclk_lvl),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  sfrx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .USE_FILTER(1'b0)) u_sdata (
    .clk_100M (clk_100M),
    .rst      (rst),
    .din      (sdata),
    .level    (sdata_lvl),
    .rise     (sdata_rise),
    .fall     (sdata_fall)
  );

  sfrx_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .USE_FILTER(FILT_EN)) u_sync (
    .clk_100M (clk_100M),
    .rst      (rst),
    .din      (sync),
    .level    (sync_lvl),
    .rise     (sync_rise),
    .fall     (sync_fall)
  );

  assign unused_edges = ^{sclk_lvl, sclk_rise, sdata_rise, sdata_fall};

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state <= ST_WAIT_HIGH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT_HIGH: if (sync_lvl && settle_cnt == 8'd0) state_nxt = ST_IDLE;
      ST_IDLE:      if (sync_fall) state_nxt = ST_SHIFT;
      ST_SHIFT:     if (sync_rise) state_nxt = ST_IDLE;
      default:      state_nxt = ST_WAIT_HIGH;
    endcase
  end

  always_comb begin
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    case (state)
      ST_IDLE: cnt_clr = sync_fall;
      ST_SHIFT: begin
        if (sync_rise) begin
          frame_good = (bit_cnt == CNT_FULL);
          frame_bad  = (bit_cnt != CNT_FULL);
        end else begin
          shift_en = sclk_fall;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (state != ST_WAIT_HIGH || !sync_lvl) begin
      settle_cnt <= SETTLE_LOAD;
    end else if (settle_cnt != 8'd0) begin
      settle_cnt <= settle_cnt - 8'd1;
    end
  end

  // Counter saturates one past FRAME_BITS so an over-long frame can never alias to a good count.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cnt_clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_BITS-2:0], sdata_lvl};
      if (bit_cnt != CNT_SAT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= 1'b0;
      if (frame_good) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (!word_valid || word_ready) begin
          word       <= shreg;
          word_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized and directed bench for serial_frame_rx against a transaction-level model.
`timescale 1ns/1ps
module tb_serial_frame_rx;
  import sfrx_pkg::*;

  localparam int FB = 24;
`ifdef SFRX_GLITCH_FILTER_EN
  localparam int EXP_LAT = 6;
`else
  localparam int EXP_LAT = 4;
`endif

  logic          clk_100M = 1'b0;
  logic          rst = 1'b1;
  logic          sclk = 1'b1;
  logic          sdata = 1'b0;
  logic          sync = 1'b1;
  logic          word_ready = 1'b1;
  logic [FB-1:0] word;
  logic          word_valid;
  logic          frame_err;
  logic          overrun;
  logic [15:0]   frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [FB-1:0] got_q[$];
  int            err_seen  = 0;
  int            ovr_seen  = 0;
  int            vld_rises = 0;
  logic          vld_prev  = 1'b0;

  logic [FB-1:0] exp_q[$];
  int            exp_err   = 0;
  int            exp_ovr   = 0;
  logic [15:0]   exp_cnt   = 16'd0;
  bit            pending   = 1'b0;
  logic [FB-1:0] pend_word = '0;

  always #5 clk_100M = ~clk_100M;

  serial_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .sclk       (sclk),
    .sdata      (sdata),
    .sync       (sync),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  // Inputs only change just after posedge, so the negedge view is what the next edge samples.
  always @(negedge clk_100M) begin
    if (word_valid === 1'b1 && word_ready === 1'b1) got_q.push_back(word);
    if (frame_err === 1'b1) err_seen++;
    if (overrun === 1'b1) ovr_seen++;
    if (word_valid === 1'b1 && vld_prev !== 1'b1) vld_rises++;
    vld_prev = word_valid;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100M);
      #2;
    end
  endtask

  task automatic send_bits(input logic [31:0] data, input int hi, input int lo,
                           input int half, input int glitch_bit);
    for (int i = hi; i >= lo; i--) begin
      sdata = data[i];
      if (i == glitch_bit) begin
        tick(half / 2);
        sclk = 1'b0;
        tick(1);
        sclk = 1'b1;
        tick(half - half / 2 - 1);
      end else begin
        tick(half);
      end
      sclk = 1'b0;
      tick(half);
      sclk = 1'b1;
    end
  endtask

  task automatic end_frame(output int lat);
    sync = 1'b1;
    lat  = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_100M);
      #1;
      if (word_valid === 1'b1 && lat < 0) lat = k;
    end
    #1;
    tick(30);
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input int half,
                            input int glitch_bit, output int lat);
    sync = 1'b0;
    tick(half);
    send_bits(data, nbits - 1, 0, half, glitch_bit);
    tick(half);
    end_frame(lat);
  endtask

  task automatic set_ready(input logic r);
    word_ready = r;
    if (r && pending) begin
      exp_q.push_back(pend_word);
      pending = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [31:0] data, input int nbits);
    if (nbits != FB) begin
      exp_err++;
    end else begin
      exp_cnt++;
      if (pending) begin
        exp_ovr++;
      end else if (word_ready) begin
        exp_q.push_back(data[FB-1:0]);
      end else begin
        pending   = 1'b1;
        pend_word = data[FB-1:0];
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_cnt"}, frame_cnt, exp_cnt);
    check_val({tag, "_err"}, err_seen, exp_err);
    check_val({tag, "_ovr"}, ovr_seen, exp_ovr);
    check_val({tag, "_nwords"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_val({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    if (pending) begin
      check_val({tag, "_held_word"}, word, pend_word);
      check_val({tag, "_held_valid"}, word_valid, 1);
    end
  endtask

  initial begin
    int lat;

    rst = 1'b1;
    tick(3);
    check_val("rst_word", word, 0);
    check_val("rst_valid", word_valid, 0);
    check_val("rst_err", frame_err, 0);
    check_val("rst_ovr", overrun, 0);
    check_val("rst_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick(20);

    // Good frame at 1 MHz sclk, consumer always ready
    vld_rises = 0;
    set_ready(1'b1);
    send_frame({8'h00, CTRL_LOAD_A, 16'hABCD}, FB, 50, -1, lat);
    model_frame({8'h00, CTRL_LOAD_A, 16'hABCD}, FB);
    check_val("basic_latency", lat, EXP_LAT);
    check_val("basic_vld_pulses", vld_rises, 1);
    check_all("basic");

    send_frame(32'h0000_0ABC, 12, 50, -1, lat);
    model_frame(32'h0000_0ABC, 12);
    check_val("short_vld_pulses", vld_rises, 1);
    check_all("short");

    send_frame(32'h0155_5555, 25, 50, -1, lat);
    model_frame(32'h0155_5555, 25);
    check_val("long_vld_pulses", vld_rises, 1);
    check_all("long");

    // Consumer stalled: second good frame must be dropped
    set_ready(1'b0);
    send_frame({8'h00, CTRL_LOAD_A, 16'h000F}, FB, 50, -1, lat);
    model_frame({8'h00, CTRL_LOAD_A, 16'h000F}, FB);
    send_frame({8'h00, CTRL_LOAD_B, 16'h00F0}, FB, 50, -1, lat);
    model_frame({8'h00, CTRL_LOAD_B, 16'h00F0}, FB);
    check_all("overrun");
    set_ready(1'b1);
    tick(5);
    check_all("drain");

    // Reset mid-frame, sync held low through the rest of that frame
    sync = 1'b0;
    tick(50);
    send_bits(32'h00FF_FFFF, 23, 14, 50, -1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    exp_cnt = 16'd0;
    pending = 1'b0;
    send_bits(32'h00FF_FFFF, 13, 0, 50, -1);
    tick(50);
    sync = 1'b1;
    tick(40);
    check_all("rst_mid");
    send_frame({8'h00, CTRL_LOAD_B, 16'h1234}, FB, 50, -1, lat);
    model_frame({8'h00, CTRL_LOAD_B, 16'h1234}, FB);
    check_val("after_rst_latency", lat, EXP_LAT);
    check_all("after_rst");

`ifdef SFRX_GLITCH_FILTER_EN
    send_frame({8'h00, CTRL_LOAD_A, 16'h5A3C}, FB, 50, 12, lat);
    model_frame({8'h00, CTRL_LOAD_A, 16'h5A3C}, FB);
    check_val("glitch_latency", lat, EXP_LAT);
    check_all("glitch");
`endif

    for (int it = 0; it < 12; it++) begin
      logic        r;
      int          len;
      int          half;
      logic [31:0] data;
      r    = ($urandom_range(0, 3) != 0);
      len  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(12, 30)) : FB;
      half = int'($urandom_range(4, 12));
      data = {8'h00, ($urandom_range(0, 1) == 1) ? CTRL_LOAD_A : CTRL_LOAD_B, 16'($urandom)};
      if (len > FB) data = $urandom;
      set_ready(r);
      tick(3);
      send_frame(data, len, half, -1, lat);
      model_frame(data, len);
      if (r && len == FB) check_val("rand_latency", lat, EXP_LAT);
      check_all("rand");
    end

    set_ready(1'b1);
    tick(5);
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter: FRAME_BITS, 24, bits per frame, MSB first.
REQ-002 SHALL have parameter: SYNC_STAGES, 2, synchronizer flops per serial input (min 2).
REQ-003 SHALL have port: clk_100M  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: sclk  in  1  serial clock, asynchronous to clk_100M, idle high.
REQ-006 SHALL have port: sdata  in  1  serial data, asynchronous.
REQ-007 SHALL have port: sync  in  1  frame strobe, active-low, asynchronous, idle high.
REQ-008 SHALL have port: word  out  FRAME_BITS  last accepted frame; bits [23:16] control, [15:0] value.
REQ-009 SHALL have port: word_valid  out  1  word holds an unconsumed frame.
REQ-010 SHALL have port: word_ready  in  1  consumer accepts word when word_valid and word_ready are both high.
REQ-011 SHALL have port: frame_err  out  1  one-cycle pulse, frame bit count not equal to FRAME_BITS.
REQ-012 SHALL have port: overrun  out  1  one-cycle pulse, good frame dropped because word was still pending.
REQ-013 SHALL have port: frame_cnt  out  16  good frames received, wraps 0xFFFF to 0x0000.

Function
REQ-014 SHALL pass sclk, sdata and sync through SYNC_STAGES flops, then one edge-detect flop, before use.
REQ-015 SHALL run FSM states IDLE, SHIFT, WAIT_HIGH.
REQ-016 IDLE: on synchronized sync falling edge, SHALL clear the bit counter and enter SHIFT.
REQ-017 SHIFT: on each synchronized sclk falling edge, SHALL shift synchronized sdata into the LSB of the shift register and increment the bit counter.
REQ-018 SHIFT: on synchronized sync rising edge with count == FRAME_BITS, SHALL complete a good frame and return to IDLE.
REQ-019 SHIFT: on sync rising edge with count != FRAME_BITS, SHALL pulse frame_err, discard the data and return to IDLE.
REQ-020 SHIFT: the bit counter SHALL saturate at FRAME_BITS+1 so that a long frame never reads as good.
REQ-021 A good frame SHALL load word, set word_valid and increment frame_cnt.
REQ-022 word_valid SHALL rise on the 4th clk_100M edge after the sync pin rises (SYNC_STAGES=2, filter off), given setup is met.
REQ-023 word_valid SHALL clear on the cycle after a handshake, unless a new good frame completes in that same cycle.
REQ-024 If a handshake and a good frame completion coincide, the new frame SHALL load and word_valid SHALL stay high.
REQ-025 If a good frame completes while word_valid=1 and word_ready=0, SHALL keep the old word, drop the new one, pulse overrun and still increment frame_cnt.
REQ-026 sclk and sdata edges SHALL be ignored in IDLE and WAIT_HIGH.
REQ-027 WAIT_HIGH: SHALL wait for synchronized sync high, then enter IDLE.

Reset
REQ-028 On rst: word=0, word_valid=0, frame_err=0, overrun=0, frame_cnt=0, shift register and counter=0, synchronizer flops=1.
REQ-029 Out of reset the FSM SHALL enter WAIT_HIGH, so a frame already in progress is never accepted.
REQ-030 rst asserted mid-frame SHALL discard the partial frame with no frame_err pulse.

Configuration
REQ-031 SFRX_GLITCH_FILTER_EN defined: synchronized sclk and sync SHALL each pass a 3-sample majority filter, so only states stable for 2 of 3 consecutive samples propagate; this adds exactly 2 cycles to REQ-022 latency (6 cycles).
REQ-032 SFRX_GLITCH_FILTER_EN undefined: no filter; the synchronizer output feeds edge detection directly.

Structure
REQ-033 Package sfrx_pkg SHALL hold the FSM state enum, the default FRAME_BITS and control constants CTRL_LOAD_A=8'h10 and CTRL_LOAD_B=8'h24.
REQ-034 Sub-module sfrx_sync_edge SHALL implement synchronizer, optional filter and rise/fall pulses, instantiated once each for sclk, sdata and sync.

Verification
REQ-035 Frame 24'h10ABCD, 1 MHz sclk, word_ready=1 -> one word_valid pulse, word=24'h10ABCD, frame_cnt=1.
REQ-036 12-bit frame, then sync high -> frame_err pulses once, word_valid stays 0, frame_cnt unchanged.
REQ-037 25-bit frame -> frame_err pulses once, no word.
REQ-038 word_ready=0, frames 24'h10000F then 24'h2400F0 -> word stays 24'h10000F, overrun pulses once, frame_cnt=2.
REQ-039 rst pulsed after bit 10 with sync held low to the end of the frame, then a clean frame 24'h241234 -> only 24'h241234 is delivered, no frame_err.
REQ-040 With SFRX_GLITCH_FILTER_EN, a 1-cycle sclk low glitch injected mid-frame -> frame still decodes correctly, and latency is 6 cycles.
